fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

- Generates the 3-bit operand-select codes driving the execute-stage 5:1 operand multiplexers, plus stall and flush controls for the 5-stage pipeline.
- Keeps its own shadow pipeline of destination-register metadata (E, M, W, and one retired stage X), so selects are computed in Decode and registered into Execute.
- Detects load-use hazards and serialises CSR instructions with a stall counter.
- Handles taken-branch flushes.

## Interface
Parameters:
- `CSR_STALL_CYCLES`, default 2: Decode hold cycles after a CSR instruction enters E; legal range 0–7.

Ports (the only `reset` is asynchronous, active-high; single clock `clk`):
- `clk` in 1: pipeline clock.
- `reset` in 1: asynchronous, active-high reset.
- `Rs1D`, `Rs2D` in 5 each: Decode source registers.
- `RdD` in 5: Decode destination register.
- `RegWriteD` in 1: Decode instruction writes `RdD`.
- `UseRs1D`, `UseRs2D` in 1 each: Decode instruction actually reads that operand.
- `IsLoadD`, `IsCsrD` in 1 each: Decode instruction is a load or a CSR access.
- `PCSrcE` in 1: taken branch or jump resolved in E.
- `StallF`, `StallD` out 1 each: hold PC and the IF/ID register.
- `FlushD`, `FlushE` out 1 each: bubble IF/ID and ID/EX.
- `ForwardAE`, `ForwardBE` out 3 each: operand select codes, registered.

## Operation
Select encoding (shared constants):
- 000 = register file.
- 001 = M-stage ALU result.
- 010 = W-stage result.
- 011 = M-stage CSR read data.
- 100 = X-stage (retired) result.
- 101–111 are never driven.

Shadow stages:
- Each of E, M, W, X holds {`valid`, `rd`, `regwrite`, `is_load`, `is_csr`}.
- Every cycle: X←W, M→W, E→M.
- E←Decode fields when Decode advances; E←bubble (`valid`=0) when `FlushE`.

Next select for `Rs1D` (identical logic for `Rs2D`), first match wins; a "match" requires `valid`, `regwrite`, `rd`==`Rs1D`, and `Rs1D`≠0:
- Match in E: 011 if E.`is_csr`, else 001.
- Match in M: 010.
- Match in W: 100.
- Otherwise: 000.
- Registered into `ForwardAE` when Decode advances; forced to 000 when `FlushE`.

Load-use hazard:
- Condition: E.`valid` & E.`is_load` & E.`rd`≠0 & ((`UseRs1D` & `Rs1D`==E.`rd`) | (`UseRs2D` & `Rs2D`==E.`rd`)).
- Response: `StallF`=`StallD`=1 and `FlushE`=1 for exactly one cycle.
- The next cycle, the load is in M, so the select resolves to 010 and is registered when Decode advances.

CSR serialisation:
- 3-bit counter `csr_cnt`, loaded with `CSR_STALL_CYCLES` when a valid CSR instruction enters E.
- While `csr_cnt`≠0: `StallF`=`StallD`=1, `FlushE`=1, and `csr_cnt` decrements each cycle.

Branch flush:
- `PCSrcE` forces `FlushD`=`FlushE`=1.
- Clears `csr_cnt` and overrides all stalls: `StallF`=`StallD`=0.
- Flush has priority over both stall sources in the same cycle.
- The branch in E is itself retained and advances to M.

Simultaneous events:
- Load-use and CSR stall together give the union of stalls.
- The counter keeps decrementing during a load-use stall.

## Timing
- `StallF`, `StallD`, `FlushD`, `FlushE` are combinational from shadow state, `csr_cnt`, Decode inputs and `PCSrcE`.
- `ForwardAE`/`ForwardBE` are registered and valid during the cycle their instruction occupies E; one-cycle latency from Decode.
- Reset (asynchronous, takes effect immediately, including mid-stall):
  - All shadow `valid`=0.
  - `csr_cnt`=0.
  - `ForwardAE`=`ForwardBE`=000.
  - Therefore `StallF`/`StallD`/`FlushD`/`FlushE`=0.
- First post-reset cycle behaves as an empty pipeline.
- `CSR_STALL_CYCLES`=0 disables CSR stalls entirely.

## Structure
- Package `fwd_pkg` holds:
  - the `FWD_RF`/`FWD_M_ALU`/`FWD_W`/`FWD_M_CSR`/`FWD_X` localparam encodings;
  - the shadow-stage struct typedef.
- One sub-module, `fwd_sel_calc`: combinational per-operand priority encoder, instantiated twice (Rs1, Rs2).

## Test plan
- ADD x5 then SUB using x5 back-to-back → `ForwardAE`=001 in SUB's E cycle; no stall.
- Writer of x7, two NOPs, then reader of x7 → `ForwardBE`=100.
- LW x3, then ADD x4,x3,x1:
  - one-cycle `StallD`/`StallF`/`FlushE`;
  - ADD then sees `ForwardAE`=010.
- CSRRW x9 followed by a reader of x9 with `CSR_STALL_CYCLES`=2:
  - exactly 2 stall cycles;
  - reader gets `ForwardAE`=100, since the CSR instruction has reached X by the time the reader enters E.
- `PCSrcE` asserted during a load-use stall → `FlushD`=`FlushE`=1, `StallD`=0, `csr_cnt` cleared.
- Writes to x0 → select always 000.
- Reset asserted mid-CSR-stall → all outputs 0 in the same cycle.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared encodings and shadow-stage record for the forwarding/hazard unit.
package fwd_pkg;

    // Execute-stage operand multiplexer select codes (101..111 never driven)
    localparam logic [2:0] FWD_RF    = 3'b000;
    localparam logic [2:0] FWD_M_ALU = 3'b001;
    localparam logic [2:0] FWD_W     = 3'b010;
    localparam logic [2:0] FWD_M_CSR = 3'b011;
    localparam logic [2:0] FWD_X     = 3'b100;

    // Destination-register metadata carried down the shadow pipeline
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       is_load;
        logic       is_csr;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/fwd_sel_calc.sv
// Per-operand priority encoder: picks the youngest in-flight writer of rs.
// Selects are named for where the producer will be once the reader reaches E.
module fwd_sel_calc (
    input  logic [4:0] rs_i,
    input  logic       e_valid_i,
    input  logic       e_regwrite_i,
    input  logic [4:0] e_rd_i,
    input  logic       e_is_csr_i,
    input  logic       m_valid_i,
    input  logic       m_regwrite_i,
    input  logic [4:0] m_rd_i,
    input  logic       w_valid_i,
    input  logic       w_regwrite_i,
    input  logic [4:0] w_rd_i,
    output logic [2:0] sel_o
);
    import fwd_pkg::*;

    logic rs_nz;
    logic e_hit;
    logic m_hit;
    logic w_hit;

    // x0 is hardwired zero, so it never matches a producer
    assign rs_nz = (rs_i != 5'd0);
    assign e_hit = rs_nz & e_valid_i & e_regwrite_i & (e_rd_i == rs_i);
    assign m_hit = rs_nz & m_valid_i & m_regwrite_i & (m_rd_i == rs_i);
    assign w_hit = rs_nz & w_valid_i & w_regwrite_i & (w_rd_i == rs_i);

    // Youngest producer wins; a CSR in E delivers its read data from M next cycle
    always_comb begin
        sel_o = FWD_RF;
        if (e_hit) begin
            sel_o = e_is_csr_i ? FWD_M_CSR : FWD_M_ALU;
        end else if (m_hit) begin
            sel_o = FWD_W;
        end else if (w_hit) begin
            sel_o = FWD_X;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects, load-use / CSR stalls and branch flushes for a 5-stage pipe.
module fwd_hazard_unit #(
    parameter int CSR_STALL_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] RdD,
    input  logic       RegWriteD,
    input  logic       UseRs1D,
    input  logic       UseRs2D,
    input  logic       IsLoadD,
    input  logic       IsCsrD,
    input  logic       PCSrcE,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic [2:0] ForwardAE,
    output logic [2:0] ForwardBE
);
    import fwd_pkg::*;

    localparam logic [2:0] CSR_LOAD = 3'(CSR_STALL_CYCLES);

    stage_t     e_q, e_d, m_q, w_q, x_q;
    logic [2:0] csr_cnt_q, csr_cnt_d;
    logic [2:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [2:0] sel_a, sel_b;
    logic       load_use;
    logic       csr_hold;
    logic       hold;
    logic       unused_retired;

    // Load in E whose result a Decode operand actually needs
    assign load_use = e_q.valid & e_q.is_load & (e_q.rd != 5'd0) &
                      ((UseRs1D & (Rs1D == e_q.rd)) | (UseRs2D & (Rs2D == e_q.rd)));
    assign csr_hold = (csr_cnt_q != 3'd0);
    assign hold     = load_use | csr_hold;

    // A taken branch squashes Decode, so holding it would be pointless
    assign StallF    = hold & ~PCSrcE;
    assign StallD    = hold & ~PCSrcE;
    assign FlushD    = PCSrcE;
    assign FlushE    = PCSrcE | hold;
    assign ForwardAE = fwd_a_q;
    assign ForwardBE = fwd_b_q;

    // X is the retired copy of W; a W hit already produces the X select, so
    // nothing here consumes it beyond keeping the shadow pipe complete.
    assign unused_retired = ^x_q;

    fwd_sel_calc u_sel_a (
        .rs_i(Rs1D),
        .e_valid_i(e_q.valid), .e_regwrite_i(e_q.regwrite), .e_rd_i(e_q.rd), .e_is_csr_i(e_q.is_csr),
        .m_valid_i(m_q.valid), .m_regwrite_i(m_q.regwrite), .m_rd_i(m_q.rd),
        .w_valid_i(w_q.valid), .w_regwrite_i(w_q.regwrite), .w_rd_i(w_q.rd),
        .sel_o(sel_a)
    );

    fwd_sel_calc u_sel_b (
        .rs_i(Rs2D),
        .e_valid_i(e_q.valid), .e_regwrite_i(e_q.regwrite), .e_rd_i(e_q.rd), .e_is_csr_i(e_q.is_csr),
        .m_valid_i(m_q.valid), .m_regwrite_i(m_q.regwrite), .m_rd_i(m_q.rd),
        .w_valid_i(w_q.valid), .w_regwrite_i(w_q.regwrite), .w_rd_i(w_q.rd),
        .sel_o(sel_b)
    );

    // Decode enters E (with its selects) unless E is being bubbled
    always_comb begin
        e_d     = STAGE_BUBBLE;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (!FlushE) begin
            e_d.valid    = 1'b1;
            e_d.rd       = RdD;
            e_d.regwrite = RegWriteD;
            e_d.is_load  = IsLoadD;
            e_d.is_csr   = IsCsrD;
            fwd_a_d      = sel_a;
            fwd_b_d      = sel_b;
        end
    end

    // CSR serialisation counter: branch clears, CSR entering E loads, else count down
    always_comb begin
        csr_cnt_d = csr_cnt_q;
        if (PCSrcE) begin
            csr_cnt_d = 3'd0;
        end else if (!FlushE && IsCsrD) begin
            csr_cnt_d = CSR_LOAD;
        end else if (csr_hold) begin
            csr_cnt_d = csr_cnt_q - 3'd1;
        end
    end

    // Shadow pipeline, counter and registered selects
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q       <= STAGE_BUBBLE;
            m_q       <= STAGE_BUBBLE;
            w_q       <= STAGE_BUBBLE;
            x_q       <= STAGE_BUBBLE;
            csr_cnt_q <= 3'd0;
            fwd_a_q   <= FWD_RF;
            fwd_b_q   <= FWD_RF;
        end else begin
            e_q       <= e_d;
            m_q       <= e_q;
            w_q       <= m_q;
            x_q       <= w_q;
            csr_cnt_q <= csr_cnt_d;
            fwd_a_q   <= fwd_a_d;
            fwd_b_q   <= fwd_b_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed cycle table, CSR_STALL_CYCLES=0 check,
// then randomized traffic against an age-ordered reference model.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] Rs1D = '0, Rs2D = '0, RdD = '0;
    logic       RegWriteD = 0, UseRs1D = 0, UseRs2D = 0, IsLoadD = 0, IsCsrD = 0, PCSrcE = 0;

    logic       stf2, std2, fld2, fle2;
    logic [2:0] fa2, fb2;
    logic       stf0, std0, fld0, fle0;
    logic [2:0] fa0, fb0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.CSR_STALL_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
        .UseRs1D(UseRs1D), .UseRs2D(UseRs2D), .IsLoadD(IsLoadD), .IsCsrD(IsCsrD), .PCSrcE(PCSrcE),
        .StallF(stf2), .StallD(std2), .FlushD(fld2), .FlushE(fle2), .ForwardAE(fa2), .ForwardBE(fb2)
    );

    fwd_hazard_unit #(.CSR_STALL_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
        .UseRs1D(UseRs1D), .UseRs2D(UseRs2D), .IsLoadD(IsLoadD), .IsCsrD(IsCsrD), .PCSrcE(PCSrcE),
        .StallF(stf0), .StallD(std0), .FlushD(fld0), .FlushE(fle0), .ForwardAE(fa0), .ForwardBE(fb0)
    );

    task automatic chk(input string nm, input int idx, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0d: got %0d want %0d", nm, idx, act, exp);
        end
    endtask

    // k=0 -> CSR_STALL_CYCLES=2 instance, k=1 -> CSR_STALL_CYCLES=0 instance
    task automatic chk_all(input int k, input int idx, input bit st, input bit fd, input bit fe,
                           input bit [2:0] fa, input bit [2:0] fb);
        if (k == 0) begin
            chk("StallF", idx, {2'b0, stf2}, {2'b0, st});
            chk("StallD", idx, {2'b0, std2}, {2'b0, st});
            chk("FlushD", idx, {2'b0, fld2}, {2'b0, fd});
            chk("FlushE", idx, {2'b0, fle2}, {2'b0, fe});
            chk("ForwardAE", idx, fa2, fa);
            chk("ForwardBE", idx, fb2, fb);
        end else begin
            chk("StallF_p0", idx, {2'b0, stf0}, {2'b0, st});
            chk("StallD_p0", idx, {2'b0, std0}, {2'b0, st});
            chk("FlushD_p0", idx, {2'b0, fld0}, {2'b0, fd});
            chk("FlushE_p0", idx, {2'b0, fle0}, {2'b0, fe});
            chk("ForwardAE_p0", idx, fa0, fa);
            chk("ForwardBE_p0", idx, fb0, fb);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 later
    task automatic drive(input bit rst, input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd,
                         input bit rw, input bit u1, input bit u2, input bit ld, input bit csr, input bit br);
        @(posedge clk);
        #1;
        reset = rst; Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw;
        UseRs1D = u1; UseRs2D = u2; IsLoadD = ld; IsCsrD = csr; PCSrcE = br;
        #3;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit       rst;
        bit [4:0] rs1, rs2, rd;
        bit       rw, u, ld, csr, br;
        bit       st, fd, fe;
        bit [2:0] fa, fb;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd,
                       input bit rw, input bit u, input bit ld, input bit csr, input bit br,
                       input bit st, input bit fd, input bit fe, input bit [2:0] fa, input bit [2:0] fb);
        vec_t v;
        v = '{rst, rs1, rs2, rd, rw, u, ld, csr, br, st, fd, fe, fa, fb};
        tbl.push_back(v);
    endtask

    // ---------------- reference model ----------------
    // win[k][age]: what entered E 1, 2, 3 edges ago (age 0 = currently in E)
    typedef struct { bit v; bit [4:0] rd; bit rw, ld, csr; } ins_t;
    ins_t     win[2][3];
    int       cnt[2];
    bit [2:0] mfa[2], mfb[2];
    int       hold_len[2] = '{2, 0};

    function automatic bit [2:0] ref_sel(input int k, input bit [4:0] rs);
        for (int age = 0; age < 3; age++) begin
            if (rs != 0 && win[k][age].v && win[k][age].rw && win[k][age].rd == rs) begin
                if (age == 0) return win[k][age].csr ? 3'd3 : 3'd1;
                if (age == 1) return 3'd2;
                return 3'd4;
            end
        end
        return 3'd0;
    endfunction

    task automatic model_reset(input int k);
        for (int a = 0; a < 3; a++) win[k][a] = '{1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
        cnt[k] = 0; mfa[k] = 0; mfb[k] = 0;
    endtask

    task automatic model_cycle(input int k, input int idx, input bit rst);
        bit lu, hold, st, fe;
        bit [2:0] na, nb;
        if (rst) model_reset(k);
        lu = win[k][0].v && win[k][0].ld && win[k][0].rd != 0 &&
             ((UseRs1D && Rs1D == win[k][0].rd) || (UseRs2D && Rs2D == win[k][0].rd));
        hold = lu || cnt[k] > 0;
        st = hold && !PCSrcE;
        fe = hold || PCSrcE;
        chk_all(k, idx, st, PCSrcE, fe, mfa[k], mfb[k]);
        if (!rst) begin
            na = fe ? 3'd0 : ref_sel(k, Rs1D);
            nb = fe ? 3'd0 : ref_sel(k, Rs2D);
            if (PCSrcE) cnt[k] = 0;
            else if (!fe && IsCsrD) cnt[k] = hold_len[k];
            else if (cnt[k] > 0) cnt[k] = cnt[k] - 1;
            win[k][2] = win[k][1];
            win[k][1] = win[k][0];
            win[k][0] = fe ? '{1'b0, 5'd0, 1'b0, 1'b0, 1'b0} : '{1'b1, RdD, RegWriteD, IsLoadD, IsCsrD};
            mfa[k] = na;
            mfb[k] = nb;
        end
    endtask

    initial begin
        // rst  rs1 rs2 rd rw u ld csr br | st fd fe fa fb
        add(1,  0, 0, 0, 0,0,0,0,0,  0,0,0, 0,0); // reset
        add(0,  1, 2, 5, 1,1,0,0,0,  0,0,0, 0,0); // ADD x5
        add(0,  5, 1, 6, 1,1,0,0,0,  0,0,0, 0,0); // SUB reads x5
        add(0,  0, 0, 0, 0,0,0,0,0,  0,0,0, 1,0); // SUB in E: M ALU forward
        add(0,  1, 1, 7, 1,1,0,0,0,  0,0,0, 0,0); // writer x7
        add(0,  0, 0, 0, 0,0,0,0,0,  0,0,0, 0,0);
        add(0,  0, 0, 0, 0,0,0,0,0,  0,0,0, 0,0);
        add(0,  2, 7, 8, 1,1,0,0,0,  0,0,0, 0,0); // reader x7 on rs2
        add(0,  0, 0, 0, 0,0,0,0,0,  0,0,0, 0,4); // X forward
        add(0,  2, 0, 3, 1,1,1,0,0,  0,0,0, 0,0); // LW x3
        add(0,  3, 1, 4, 1,1,0,0,0,  1,0,1, 0,0); // ADD x4,x3,x1: load-use
        add(0,  3, 1, 4, 1,1,0,0,0,  0,0,0, 0,0); // ADD retried
        add(0,  0, 0, 0, 0,0,0,0,0,  0,0,0, 2,0); // W forward
        add(0,  1, 0, 9, 1,1,0,1,0,  0,0,0, 0,0); // CSRRW x9
        add(0,  9, 0,10, 1,1,0,0,0,  1,0,1, 0,0); // reader held
        add(0,  9, 0,10, 1,1,0,0,0,  1,0,1, 0,0);
        add(0,  9, 0,10, 1,1,0,0,0,  0,0,0, 0,0); // released
        add(0,  0, 0, 0, 0,0,0,0,0,  0,0,0, 4,0); // CSR result from X
        add(0,  0, 0, 3, 1,1,1,0,0,  0,0,0, 0,0); // LW x3
        add(0,  3, 0, 4, 1,1,0,0,1,  0,1,1, 0,0); // load-use + branch
        add(0,  0, 0, 0, 0,0,0,0,0,  0,0,0, 0,0);
        add(0,  0, 0, 9, 1,1,0,1,0,  0,0,0, 0,0); // CSR
        add(0,  0, 0, 0, 0,1,0,0,1,  0,1,1, 0,0); // branch during CSR stall
        add(0,  0, 0, 0, 0,0,0,0,0,  0,0,0, 0,0); // counter cleared
        add(0,  0, 0, 0, 0,0,0,0,0,  0,0,0, 0,0);
        add(0,  1, 0, 0, 1,1,0,0,0,  0,0,0, 0,0); // ADD x0
        add(0,  0, 0, 5, 0,1,0,0,0,  0,0,0, 0,0); // reads x0
        add(0,  0, 0, 0, 1,1,1,0,0,  0,0,0, 0,0); // LW x0
        add(0,  0, 0, 0, 0,1,0,0,0,  0,0,0, 0,0); // reads x0 after LW x0: no stall
        add(0,  0, 0, 0, 0,0,0,0,0,  0,0,0, 0,0);
        add(0,  0, 0, 3, 1,1,1,0,0,  0,0,0, 0,0); // LW x3
        add(0,  3, 3, 0, 0,0,0,0,0,  0,0,0, 0,0); // names x3 but uses neither
        add(0,  0, 0, 0, 0,0,0,0,0,  0,0,0, 1,1); // selects still computed
        add(0,  0, 0, 9, 1,1,0,1,0,  0,0,0, 0,0); // CSR
        add(0,  0, 0, 0, 0,0,0,0,0,  1,0,1, 0,0); // stalling
        add(1,  0, 0, 0, 0,0,0,0,0,  0,0,0, 0,0); // reset mid-stall
        add(0,  0, 0, 0, 0,0,0,0,0,  0,0,0, 0,0); // empty pipeline

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].rw, tbl[i].u, tbl[i].u,
                  tbl[i].ld, tbl[i].csr, tbl[i].br);
            chk_all(0, i, tbl[i].st, tbl[i].fd, tbl[i].fe, tbl[i].fa, tbl[i].fb);
        end

        // CSR_STALL_CYCLES=0 never stalls and exposes the M-stage CSR select
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_all(1, 100, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 9, 1, 1, 1, 0, 1, 0);
        chk_all(1, 101, 0, 0, 0, 0, 0);
        drive(0, 9, 0, 10, 1, 1, 1, 0, 0, 0);
        chk_all(1, 102, 0, 0, 0, 0, 0);
        chk_all(0, 102, 1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_all(1, 103, 0, 0, 0, 3, 0);
        chk_all(0, 103, 1, 0, 1, 0, 0);

        // Randomized traffic, both parameterisations against the model
        model_reset(0);
        model_reset(1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            bit rst;
            rst = ($urandom_range(0, 99) == 0);
            @(posedge clk);
            #1;
            reset     = rst;
            Rs1D      = 5'($urandom_range(0, 7));
            Rs2D      = 5'($urandom_range(0, 7));
            RdD       = 5'($urandom_range(0, 7));
            RegWriteD = ($urandom_range(0, 9) < 7);
            UseRs1D   = 1'($urandom);
            UseRs2D   = 1'($urandom);
            IsLoadD   = ($urandom_range(0, 9) < 2);
            IsCsrD    = ($urandom_range(0, 9) == 0);
            PCSrcE    = rst ? 1'b0 : ($urandom_range(0, 99) < 8);
            #3;
            model_cycle(0, 1000 + c, rst);
            model_cycle(1, 1000 + c, rst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
